if_stage_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage pipeline, directly upstream of the combinational instruction memory.
- Holds the PC, drives the instruction-memory byte address and captures the returned word into the IF/ID pipeline register for decode.
- Honours freeze from the hazard unit and redirect/flush from the branch logic in EXE.
- Provides fetch/cycle counters for reporting execution clocks.

---
 rtl/if_stage_unit_pkg.sv | 8 +
 rtl/if_stage_unit_if_id_reg.sv | 30 +++
 rtl/if_stage_unit.sv | 63 ++++++
 tb/tb_if_stage_unit.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/if_stage_unit_pkg.sv
// if_stage_unit_pkg: shared opcodes and fetch constants for the IF stage
package if_stage_unit_pkg;
  localparam logic [5:0] OPC_BEZ = 6'b101000;
  localparam logic [5:0] OPC_BNE = 6'b101001;
  localparam logic [5:0] OPC_JMP = 6'b101010;
  localparam logic [31:0] NOP_INST = 32'h0;
  localparam logic [31:0] INST_BYTES = 32'd4;
endpackage

// File: rtl/if_stage_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush (priority) and freeze
module if_id_reg
  import if_stage_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        freeze,
  input  logic [31:0] next_pc,
  input  logic [31:0] next_inst,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        valid_out
);
  // flush inserts a bubble, freeze holds, otherwise capture the fetch
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_out    <= '0;
      inst_out  <= NOP_INST;
      valid_out <= 1'b0;
    end else if (flush) begin
      pc_out    <= '0;
      inst_out  <= NOP_INST;
      valid_out <= 1'b0;
    end else if (!freeze) begin
      pc_out    <= next_pc;
      inst_out  <= next_inst;
      valid_out <= 1'b1;
    end
endmodule

// File: rtl/if_stage_unit.sv
// if_stage_unit: PC, instruction fetch, IF/ID capture, error flags and counters
module if_stage_unit
  import if_stage_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          MEM_BYTES = 1000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_address,
  output logic [31:0]          adrs,
  input  logic [31:0]          inst,
  output logic [31:0]          pc_out,
  output logic [31:0]          inst_out,
  output logic                 valid_out,
  output logic                 align_err,
  output logic                 range_err,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] fetch_cnt
);
  logic [31:0] pc;
  logic [31:0] pc_next4;
  logic [31:0] fetched;
  logic        in_range;
  logic        load;
  assign adrs     = pc;
  assign pc_next4 = pc + INST_BYTES;
  assign in_range = pc < 32'(MEM_BYTES);
  assign fetched  = in_range ? inst : NOP_INST;
  assign load     = !branch_taken && !freeze;
  // redirect beats freeze; sequential fetch wraps modulo 2^32
  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= RESET_PC;
    else if (branch_taken) pc <= {branch_address[31:2], 2'b00};
    else if (!freeze) pc <= pc_next4;
  // sticky error flags and free-running performance counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      align_err <= 1'b0;
      range_err <= 1'b0;
      cycle_cnt <= '0;
      fetch_cnt <= '0;
    end else begin
      align_err <= align_err | (branch_taken && branch_address[1:0] != 2'b00);
      range_err <= range_err | !in_range;
      cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      fetch_cnt <= load ? fetch_cnt + CNT_WIDTH'(1) : fetch_cnt;
    end
  if_id_reg u_if_id (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_taken),
    .freeze    (freeze),
    .next_pc   (pc_next4),
    .next_inst (fetched),
    .pc_out    (pc_out),
    .inst_out  (inst_out),
    .valid_out (valid_out)
  );
endmodule

// File: tb/tb_if_stage_unit.sv
// tb_if_stage_unit: directed and randomized checks against a behavioural fetch model
module tb_if_stage_unit;
  localparam int MEM = 1000;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = '0;
  logic [31:0] adrs, inst, pc_out, inst_out, cycle_cnt, fetch_cnt;
  logic        valid_out, align_err, range_err;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m_pc, m_io, m_po, m_cyc, m_fc;
  logic        m_v, m_aln, m_rng;

  if_stage_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_address(branch_address), .adrs(adrs), .inst(inst),
    .pc_out(pc_out), .inst_out(inst_out), .valid_out(valid_out),
    .align_err(align_err), .range_err(range_err),
    .cycle_cnt(cycle_cnt), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;
  assign inst = adrs + 32'd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_io = 0; m_po = 0; m_v = 0; m_aln = 0; m_rng = 0; m_cyc = 0; m_fc = 0;
  endtask

  task automatic check_model();
    chk("adrs", adrs, m_pc);
    chk("inst_out", inst_out, m_io);
    chk("pc_out", pc_out, m_po);
    chk("valid_out", 32'(valid_out), 32'(m_v));
    chk("align_err", 32'(align_err), 32'(m_aln));
    chk("range_err", 32'(range_err), 32'(m_rng));
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("fetch_cnt", fetch_cnt, m_fc);
  endtask

  task automatic cycle(input logic f, input logic b, input logic [31:0] ba);
    freeze = f; branch_taken = b; branch_address = ba;
    @(posedge clk);
    m_cyc++;
    if (m_pc >= MEM) m_rng = 1;
    if (b) begin
      if (ba % 4 != 0) m_aln = 1;
      m_pc = ba - (ba % 4);
      m_io = 0; m_po = 0; m_v = 0;
    end else if (!f) begin
      m_io = (m_pc < MEM) ? m_pc + 1 : 0;
      m_po = m_pc + 4;
      m_v = 1;
      m_fc++;
      m_pc = m_pc + 4;
    end
    #1;
    check_model();
  endtask

  task automatic reset_check();
    chk("rst adrs", adrs, 0);
    chk("rst inst_out", inst_out, 0);
    chk("rst pc_out", pc_out, 0);
    chk("rst valid", 32'(valid_out), 0);
    chk("rst align", 32'(align_err), 0);
    chk("rst range", 32'(range_err), 0);
    chk("rst cycle", cycle_cnt, 0);
    chk("rst fetch", fetch_cnt, 0);
  endtask

  initial begin
    model_reset();
    #12;
    reset_check();
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    chk("seq adrs", adrs, 12);
    chk("seq inst_out", inst_out, 9);
    chk("seq pc_out", pc_out, 12);
    chk("seq fetch", fetch_cnt, 3);
    chk("seq cycle", cycle_cnt, 3);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("frz adrs", adrs, 16);
    chk("frz inst_out", inst_out, 13);
    chk("frz pc_out", pc_out, 16);
    chk("frz fetch", fetch_cnt, 4);
    chk("frz cycle", cycle_cnt, 6);
    cycle(0, 0, 0);
    chk("frz resume", inst_out, 17);
    while (m_pc != 196) cycle(0, 0, 0);
    cycle(0, 1, 140);
    chk("br adrs", adrs, 140);
    chk("br bubble inst", inst_out, 0);
    chk("br bubble valid", 32'(valid_out), 0);
    cycle(0, 0, 0);
    chk("br target inst", inst_out, 141);
    chk("br target pc", pc_out, 144);
    cycle(1, 1, 260);
    chk("brfrz adrs", adrs, 260);
    chk("brfrz valid", 32'(valid_out), 0);
    cycle(0, 1, 32'hCE);
    chk("aln adrs", adrs, 32'hCC);
    chk("aln flag", 32'(align_err), 1);
    while (m_pc != 996) cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("rng adrs", adrs, 1000);
    cycle(0, 0, 0);
    chk("rng inst_out", inst_out, 0);
    chk("rng flag", 32'(range_err), 1);
    chk("aln sticky", 32'(align_err), 1);
    #3 rst = 1'b1;
    #1 reset_check();
    model_reset();
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic f, b;
      f = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 9) == 0);
      cycle(f, b, $urandom_range(0, 1100));
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1 reset_check();
    model_reset();
    @(negedge clk) rst = 1'b0;
    cycle(0, 0, 0);
    chk("post rst inst", inst_out, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
